// File: rtl/r5p_gpio_ctrl.sv
// GPIO controller: bus register file that drives gpio_o/gpio_e and samples gpio_i.
// Provides atomic set/clear of outputs, rise/fall edge capture into W1C status and a level irq.
module r5p_gpio_ctrl #(
  parameter int unsigned   GW      = 32,
  parameter int unsigned   AW      = 5,
  parameter logic [GW-1:0] RST_OUT = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_wen,
  input  logic [AW-1:0] req_adr,
  input  logic [3:0]    req_ben,
  input  logic [31:0]   req_wdt,
  output logic          rsp_vld,
  output logic [31:0]   rsp_rdt,
  output logic          rsp_err,
  output logic [GW-1:0] gpio_o,
  output logic [GW-1:0] gpio_e,
  input  logic [GW-1:0] gpio_i,
  output logic          irq
);

  localparam logic [2:0] IDX_OUT     = 3'd0;
  localparam logic [2:0] IDX_ENABLE  = 3'd1;
  localparam logic [2:0] IDX_IN      = 3'd2;
  localparam logic [2:0] IDX_OUT_SET = 3'd3;
  localparam logic [2:0] IDX_OUT_CLR = 3'd4;
  localparam logic [2:0] IDX_RISE_EN = 3'd5;
  localparam logic [2:0] IDX_FALL_EN = 3'd6;
  localparam logic [2:0] IDX_STATUS  = 3'd7;

  logic [GW-1:0] out_q, out_d;
  logic [GW-1:0] enable_q, enable_d;
  logic [GW-1:0] rise_en_q, rise_en_d;
  logic [GW-1:0] fall_en_q, fall_en_d;
  logic [GW-1:0] status_q, status_d;
  logic [GW-1:0] gpio_in_d_q, gpio_in_d_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [31:0]   rsp_rdt_q, rsp_rdt_d;
  logic          rsp_err_q, rsp_err_d;
  logic          irq_q, irq_d;

  logic [31:0]   adr_ext;
  logic [2:0]    idx;
  logic          mapped;
  logic          xfer;
  logic          wr_hit;
  logic          rd_hit;
  logic [31:0]   ben_mask;
  logic [31:0]   wdt_masked;
  logic [GW-1:0] wmask;
  logic [GW-1:0] wval;
  logic [GW-1:0] rise;
  logic [GW-1:0] fall;
  logic [GW-1:0] w1c;
  logic [31:0]   rd_val;
  logic          unused_bits;

  assign req_rdy = 1'b1;

  // Address is zero-extended so any AW decodes the same way; bits above the map make it unmapped.
  assign adr_ext     = 32'(req_adr);
  assign idx         = adr_ext[4:2];
  assign mapped      = (adr_ext[31:5] == 27'd0);
  assign xfer        = req_vld & req_rdy;
  assign wr_hit      = xfer & req_wen & mapped;
  assign rd_hit      = xfer & ~req_wen & mapped;
  assign ben_mask    = {{8{req_ben[3]}}, {8{req_ben[2]}}, {8{req_ben[1]}}, {8{req_ben[0]}}};
  assign wdt_masked  = req_wdt & ben_mask;
  assign wmask       = ben_mask[GW-1:0];
  assign wval        = wdt_masked[GW-1:0];
  assign unused_bits = ^{adr_ext[1:0], wdt_masked, ben_mask};

  always_comb begin
    out_d       = out_q;
    enable_d    = enable_q;
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    w1c         = '0;
    gpio_in_d_d = gpio_i;

    rise = gpio_i & ~gpio_in_d_q & rise_en_q;
    fall = ~gpio_i & gpio_in_d_q & fall_en_q;

    if (wr_hit) begin
      case (idx)
        IDX_OUT:     out_d     = (out_q & ~wmask) | wval;
        IDX_ENABLE:  enable_d  = (enable_q & ~wmask) | wval;
        IDX_OUT_SET: out_d     = out_q | wval;
        IDX_OUT_CLR: out_d     = out_q & ~wval;
        IDX_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | wval;
        IDX_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | wval;
        IDX_STATUS:  w1c       = wval;
        default:     ;
      endcase
    end

    // A new edge in the same cycle as its W1C keeps the bit set.
    status_d = (status_q & ~w1c) | rise | fall;

    case (idx)
      IDX_OUT:     rd_val = 32'(out_q);
      IDX_ENABLE:  rd_val = 32'(enable_q);
      IDX_IN:      rd_val = 32'(gpio_in_d_q);
      IDX_RISE_EN: rd_val = 32'(rise_en_q);
      IDX_FALL_EN: rd_val = 32'(fall_en_q);
      IDX_STATUS:  rd_val = 32'(status_q);
      default:     rd_val = 32'd0;
    endcase

    rsp_vld_d = xfer;
    rsp_err_d = xfer & ~mapped;
    rsp_rdt_d = rd_hit ? rd_val : 32'd0;
    irq_d     = |status_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= RST_OUT;
      enable_q    <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      status_q    <= '0;
      gpio_in_d_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rdt_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      enable_q    <= enable_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      status_q    <= status_d;
      gpio_in_d_q <= gpio_in_d_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdt_q   <= rsp_rdt_d;
      rsp_err_q   <= rsp_err_d;
      irq_q       <= irq_d;
    end
  end

  assign gpio_o  = out_q;
  assign gpio_e  = enable_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_rdt = rsp_rdt_q;
  assign rsp_err = rsp_err_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_r5p_gpio_ctrl.sv
// Bench for r5p_gpio_ctrl: register-map model checked every cycle plus literal expectations.
module tb_r5p_gpio_ctrl;

  localparam int          GW      = 32;
  localparam int          AW      = 6;
  localparam logic [31:0] RST_OUT = 32'h8000_0003;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [3:0]    req_ben = 4'h0;
  logic [31:0]   req_wdt = 32'd0;
  logic          rsp_vld;
  logic [31:0]   rsp_rdt;
  logic          rsp_err;
  logic [GW-1:0] gpio_o;
  logic [GW-1:0] gpio_e;
  logic [GW-1:0] gpio_i  = '0;
  logic          irq;

  r5p_gpio_ctrl #(.GW(GW), .AW(AW), .RST_OUT(RST_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wen(req_wen), .req_adr(req_adr),
    .req_ben(req_ben), .req_wdt(req_wdt),
    .rsp_vld(rsp_vld), .rsp_rdt(rsp_rdt), .rsp_err(rsp_err),
    .gpio_o(gpio_o), .gpio_e(gpio_e), .gpio_i(gpio_i), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: word-indexed register array; word 2 is the sampled input, words 3/4 act on word 0.
  logic [31:0] m_reg [8];
  logic [31:0] m_in_d;
  logic        e_vld, e_err, e_irq;
  logic [31:0] e_rdt;

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] bm, w, rd, edges, clr;
    int          a, word;
    bit          in_map;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) m_reg[k] = 32'd0;
      m_reg[0] = RST_OUT;
      m_in_d   = 32'd0;
      e_vld    = 1'b0;
      e_err    = 1'b0;
      e_rdt    = 32'd0;
      e_irq    = 1'b0;
    end else begin
      bm     = {{8{req_ben[3]}}, {8{req_ben[2]}}, {8{req_ben[1]}}, {8{req_ben[0]}}};
      w      = req_wdt & bm;
      a      = int'(req_adr);
      word   = a / 4;
      in_map = (a < 32);
      rd     = 32'd0;
      if (word == 2)                  rd = m_in_d;
      else if (word != 3 && word != 4) rd = (word < 8) ? m_reg[word] : 32'd0;
      edges  = (gpio_i & ~m_in_d & m_reg[5]) | (~gpio_i & m_in_d & m_reg[6]);
      e_irq  = (m_reg[7] != 32'd0);
      e_vld  = req_vld;
      e_err  = req_vld && !in_map;
      e_rdt  = (req_vld && !req_wen && in_map) ? rd : 32'd0;
      clr    = 32'd0;
      if (req_vld && req_wen && in_map) begin
        if (word == 0 || word == 1 || word == 5 || word == 6)
          m_reg[word] = (m_reg[word] & ~bm) | w;
        else if (word == 3) m_reg[0] = m_reg[0] | w;
        else if (word == 4) m_reg[0] = m_reg[0] & ~w;
        else if (word == 7) clr = w;
      end
      m_reg[7] = (m_reg[7] & ~clr) | edges;
      m_in_d   = gpio_i;
    end
  end

  always @(negedge clk) begin
    chk("req_rdy", 32'(req_rdy), 32'd1);
    chk("rsp_vld", 32'(rsp_vld), 32'(e_vld));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("rsp_rdt", rsp_rdt, e_rdt);
    chk("gpio_o",  gpio_o, m_reg[0]);
    chk("gpio_e",  gpio_e, m_reg[1]);
    chk("irq",     32'(irq), 32'(e_irq));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit wen, input logic [AW-1:0] adr, input logic [3:0] ben,
                       input logic [31:0] wdt);
    req_vld = 1'b1;
    req_wen = wen;
    req_adr = adr;
    req_ben = ben;
    req_wdt = wdt;
    tick();
  endtask

  task automatic idle(input int n);
    req_vld = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of a write transaction
    drive(1'b1, 6'h04, 4'hF, 32'h0000_00FF);
    drive(1'b1, 6'h00, 4'hF, 32'hFFFF_FFFF);
    chk("lit_pending_rsp", 32'(rsp_vld), 32'd1);
    rst_n = 1'b0;
    repeat (3) tick();
    chk("lit_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("lit_rst_gpio_o", gpio_o, RST_OUT);
    chk("lit_rst_gpio_e", gpio_e, 32'd0);
    chk("lit_rst_irq", 32'(irq), 32'd0);
    req_vld = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk("lit_rel_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("lit_rel_gpio_o", gpio_o, RST_OUT);

    // Byte-lane masked write then read-back
    drive(1'b1, 6'h00, 4'hF, 32'h0000_0000);
    drive(1'b1, 6'h00, 4'b0011, 32'hA5A5_A5A5);
    drive(1'b0, 6'h00, 4'h0, 32'd0);
    chk("lit_out_rdt", rsp_rdt, 32'h0000_A5A5);
    chk("lit_out_gpio_o", gpio_o, 32'h0000_A5A5);

    // OUT / OUT_SET / OUT_CLR back to back
    drive(1'b1, 6'h00, 4'hF, 32'h0000_00F0);
    chk("lit_b2b_rsp1", 32'(rsp_vld), 32'd1);
    drive(1'b1, 6'h0C, 4'hF, 32'h0000_000F);
    chk("lit_b2b_rsp2", 32'(rsp_vld), 32'd1);
    drive(1'b1, 6'h10, 4'hF, 32'h0000_0081);
    chk("lit_b2b_rsp3", 32'(rsp_vld), 32'd1);
    chk("lit_setclr_gpio_o", gpio_o, 32'h0000_007E);
    idle(1);
    chk("lit_b2b_rsp_end", 32'(rsp_vld), 32'd0);
    drive(1'b1, 6'h04, 4'hF, 32'h0000_FF00);
    drive(1'b0, 6'h0C, 4'h0, 32'd0);
    chk("lit_set_reads0", rsp_rdt, 32'd0);

    // Rise edge -> STATUS -> irq two cycles after the edge, then W1C
    drive(1'b1, 6'h14, 4'hF, 32'h0000_0001);
    idle(1);
    gpio_i = 32'h0000_0001;
    idle(1);
    chk("lit_irq_edge_plus1", 32'(irq), 32'd0);
    idle(1);
    chk("lit_irq_edge_plus2", 32'(irq), 32'd1);
    drive(1'b0, 6'h1C, 4'h0, 32'd0);
    chk("lit_status_rise", rsp_rdt, 32'h0000_0001);
    drive(1'b1, 6'h1C, 4'hF, 32'h0000_0001);
    idle(1);
    chk("lit_irq_w1c", 32'(irq), 32'd0);

    // Fall edge colliding with W1C of the same bit: set wins
    drive(1'b1, 6'h18, 4'hF, 32'h0000_0002);
    gpio_i = 32'h0000_0003;
    idle(2);
    gpio_i = 32'h0000_0001;
    idle(2);
    chk("lit_fall_irq", 32'(irq), 32'd1);
    gpio_i = 32'h0000_0003;
    idle(2);
    gpio_i = 32'h0000_0001;
    drive(1'b1, 6'h1C, 4'hF, 32'h0000_0002);
    idle(1);
    chk("lit_collide_irq", 32'(irq), 32'd1);
    drive(1'b0, 6'h1C, 4'h0, 32'd0);
    chk("lit_collide_status", rsp_rdt, 32'h0000_0002);
    drive(1'b1, 6'h1C, 4'hF, 32'h0000_0002);
    idle(2);
    chk("lit_clear_irq", 32'(irq), 32'd0);

    // IN register, write to IN ignored
    gpio_i = 32'h0000_1234;
    idle(2);
    drive(1'b1, 6'h08, 4'hF, 32'hFFFF_FFFF);
    drive(1'b0, 6'h08, 4'h0, 32'd0);
    chk("lit_in_rdt", rsp_rdt, 32'h0000_1234);

    // Unmapped accesses
    drive(1'b0, 6'h20, 4'h0, 32'd0);
    chk("lit_unmap_err", 32'(rsp_err), 32'd1);
    chk("lit_unmap_rdt", rsp_rdt, 32'd0);
    drive(1'b1, 6'h20, 4'hF, 32'hFFFF_FFFF);
    drive(1'b1, 6'h24, 4'hF, 32'h0000_0000);
    chk("lit_unmap_werr", 32'(rsp_err), 32'd1);
    drive(1'b0, 6'h00, 4'h0, 32'd0);
    chk("lit_unmap_out", rsp_rdt, 32'h0000_007E);
    chk("lit_unmap_err0", 32'(rsp_err), 32'd0);
    chk("lit_unmap_gpio_e", gpio_e, 32'h0000_FF00);

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 120; i++) begin
      req_vld = ($urandom_range(0, 3) != 0);
      req_wen = 1'($urandom_range(0, 1));
      req_adr = AW'($urandom_range(0, 9) * 4);
      req_ben = 4'($urandom);
      req_wdt = $urandom;
      if ($urandom_range(0, 2) == 0) gpio_i = $urandom;
      tick();
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
